// File: rtl/scarv_cop_issue_pkg.sv
// Shared definitions for the COP issue stage.
//   - issue_state_t : issue FSM encoding (2 bits), also used by COP decode
//   - issue_entry_t : one queued instruction (encoding + RS1 data)
//   - COP_RES_*     : COP execution result codes (forwarded, never decoded here)
package scarv_cop_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [31:0] enc;
        logic [31:0] rs1;
    } issue_entry_t;

    localparam int ENTRY_W = $bits(issue_entry_t);

    localparam logic [2:0] COP_RES_SUCCESS = 3'd0;
    localparam logic [2:0] COP_RES_ABORT   = 3'd1;
    localparam logic [2:0] COP_RES_BAD_INS = 3'd2;
    localparam logic [2:0] COP_RES_BAD_LAD = 3'd4;
    localparam logic [2:0] COP_RES_BAD_SAD = 3'd5;
    localparam logic [2:0] COP_RES_LD_ERR  = 3'd6;
    localparam logic [2:0] COP_RES_ST_ERR  = 3'd7;

endpackage

// File: rtl/scarv_cop_issue_fifo.sv
// Synchronous DEPTH x WIDTH FIFO for queued COP instructions.
//   g_clk, g_resetn : clock, async active-low reset
//   push, wdata     : write request/data (ignored when full or flushing)
//   pop, rdata      : read request / head entry (ignored when empty or flushing)
//   flush           : empties the FIFO; a same-cycle push is dropped
//   full, empty     : occupancy flags
module scarv_cop_issue_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge g_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/scarv_cop_issue.sv
// CPU-side issue stage in front of scarv_cop_top.
//   dec_*            : decoded COP instructions in (valid/ready) plus abort pulse
//   cpu_insn_req/enc/rs1, cop_insn_ack : request handshake towards COP
//   cpu_abort_req    : in-flight instruction has been aborted
//   cop_insn_rsp, cpu_insn_ack, cop_* : response handshake from COP
//   wb_*             : one-entry writeback slot towards the CPU regfile
//   busy             : anything queued, in flight or awaiting writeback
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO head when one is present
// REQ   | cpu_insn_req high, enc/rs1 frozen until cop_insn_ack
// WAIT  | request accepted, waiting for cop_insn_rsp
module scarv_cop_issue
    import scarv_cop_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_enc,
    input  logic [31:0] dec_rs1,
    input  logic        dec_abort,
    output logic        cpu_insn_req,
    input  logic        cop_insn_ack,
    output logic        cpu_abort_req,
    output logic [31:0] cpu_insn_enc,
    output logic [31:0] cpu_rs1,
    input  logic        cop_insn_rsp,
    output logic        cpu_insn_ack,
    input  logic        cop_wen,
    input  logic [4:0]  cop_waddr,
    input  logic [31:0] cop_wdata,
    input  logic [2:0]  cop_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_wen,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic [2:0]  wb_result,
    output logic        busy
);

    issue_state_t state, state_nxt;
    issue_entry_t fifo_wdata, fifo_rdata;
    logic         fifo_full, fifo_empty;
    logic         push, pop;
    logic         aborted, aborted_nxt;
    logic         rsp_take;

    assign fifo_wdata = '{enc: dec_enc, rs1: dec_rs1};
    assign dec_ready  = !fifo_full;
    assign push       = dec_valid && dec_ready;

    scarv_cop_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (push),
        .wdata    (fifo_wdata),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .flush    (dec_abort),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign cpu_insn_req  = (state == ST_REQ);
    assign cpu_abort_req = aborted && (state != ST_IDLE);
    // An aborted response is thrown away, so it may be accepted even with the slot full.
    assign cpu_insn_ack  = (state == ST_WAIT) && (!wb_valid || aborted);
    assign rsp_take      = cop_insn_rsp && cpu_insn_ack;
    assign busy          = !fifo_empty || (state != ST_IDLE) || wb_valid;

    always_comb begin
        state_nxt   = state;
        aborted_nxt = aborted;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                // The head is being flushed this cycle, so it must not issue.
                if (!fifo_empty && !dec_abort) begin
                    pop       = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dec_abort)    aborted_nxt = 1'b1;
                if (cop_insn_ack) state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (dec_abort) aborted_nxt = 1'b1;
                if (rsp_take) begin
                    aborted_nxt = 1'b0;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state        <= ST_IDLE;
            aborted      <= 1'b0;
            cpu_insn_enc <= '0;
            cpu_rs1      <= '0;
        end else begin
            state   <= state_nxt;
            aborted <= aborted_nxt;
            if (pop) begin
                cpu_insn_enc <= fifo_rdata.enc;
                cpu_rs1      <= fifo_rdata.rs1;
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wb_valid  <= 1'b0;
            wb_wen    <= 1'b0;
            wb_waddr  <= '0;
            wb_wdata  <= '0;
            wb_result <= '0;
        end else if (rsp_take && !aborted) begin
            wb_valid  <= 1'b1;
            wb_wen    <= cop_wen;
            wb_waddr  <= cop_waddr;
            wb_wdata  <= cop_wdata;
            wb_result <= cop_result;
        end else if (wb_valid && wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scarv_cop_issue.sv
module tb_scarv_cop_issue;

    logic        g_clk, g_resetn;
    logic        dec_valid, dec_ready, dec_abort;
    logic [31:0] dec_enc, dec_rs1;
    logic        cpu_insn_req, cop_insn_ack, cpu_abort_req;
    logic [31:0] cpu_insn_enc, cpu_rs1;
    logic        cop_insn_rsp, cpu_insn_ack;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        wb_valid, wb_ready, wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [2:0]  wb_result;
    logic        busy;

    scarv_cop_issue #(.DEPTH(2)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_enc(dec_enc),
        .dec_rs1(dec_rs1), .dec_abort(dec_abort),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_abort_req(cpu_abort_req), .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
        .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cop_result(cop_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_result(wb_result),
        .busy(busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct { logic [31:0] enc; logic [31:0] rs1; } req_t;
    typedef struct { logic wen; logic [4:0] waddr; logic [31:0] wdata; logic [2:0] result; } wb_t;

    req_t exp_req[$];
    wb_t  exp_wb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_empty(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT presented an output, required none (queue empty)", name);
    endtask

    // Monitor: scoreboard pops on each handshake, plus request-hold invariant.
    req_t        mon_r;
    wb_t         mon_w;
    logic        prev_hold;
    logic [31:0] prev_enc, prev_rs1;
    initial prev_hold = 1'b0;

    always @(negedge g_clk) begin
        if (!g_resetn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_req", cpu_insn_req, 1);
                check("hold_enc", cpu_insn_enc, prev_enc);
                check("hold_rs1", cpu_rs1, prev_rs1);
            end
            prev_hold = cpu_insn_req && !cop_insn_ack;
            prev_enc  = cpu_insn_enc;
            prev_rs1  = cpu_rs1;
            if (cpu_insn_req && cop_insn_ack) begin
                if (exp_req.size() == 0) fail_empty("req_extra");
                else begin
                    mon_r = exp_req.pop_front();
                    check("req_enc", cpu_insn_enc, mon_r.enc);
                    check("req_rs1", cpu_rs1, mon_r.rs1);
                end
            end
            if (wb_valid && wb_ready) begin
                if (exp_wb.size() == 0) fail_empty("wb_extra");
                else begin
                    mon_w = exp_wb.pop_front();
                    check("wb_wen", wb_wen, mon_w.wen);
                    check("wb_waddr", wb_waddr, mon_w.waddr);
                    check("wb_wdata", wb_wdata, mon_w.wdata);
                    check("wb_result", wb_result, mon_w.result);
                end
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic push_op(input logic [31:0] enc, input logic [31:0] rs1, input bit issues);
        int i = 0;
        req_t r;
        dec_enc   = enc;
        dec_rs1   = rs1;
        dec_valid = 1'b1;
        while (!dec_ready && i < 100) begin tick(); i++; end
        if (!dec_ready) check("push_timeout", dec_ready, 1);
        else begin
            r.enc = enc; r.rs1 = rs1;
            if (issues) exp_req.push_back(r);
            tick();
        end
        dec_valid = 1'b0;
    endtask

    task automatic wait_req();
        int i = 0;
        while (!cpu_insn_req && i < 100) begin tick(); i++; end
        check("req_timeout", cpu_insn_req, 1);
    endtask

    task automatic do_ack();
        cop_insn_ack = 1'b1;
        tick();
        cop_insn_ack = 1'b0;
    endtask

    task automatic do_rsp(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic [2:0] res, input bit expect_wb);
        int i = 0;
        wb_t w;
        cop_wen = wen; cop_waddr = waddr; cop_wdata = wdata; cop_result = res;
        cop_insn_rsp = 1'b1;
        while (!cpu_insn_ack && i < 100) begin tick(); i++; end
        check("rsp_ack_timeout", cpu_insn_ack, 1);
        w.wen = wen; w.waddr = waddr; w.wdata = wdata; w.result = res;
        if (expect_wb) exp_wb.push_back(w);
        tick();
        cop_insn_rsp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        g_resetn = 1'b0; dec_valid = 0; dec_enc = 0; dec_rs1 = 0; dec_abort = 0;
        cop_insn_ack = 0; cop_insn_rsp = 0; cop_wen = 0; cop_waddr = 0;
        cop_wdata = 0; cop_result = 0; wb_ready = 1'b1;
        tick();
        check("rst_req", cpu_insn_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_insn_ack", cpu_insn_ack, 0);
        check("rst_dec_ready", dec_ready, 1);
        tick();
        g_resetn = 1'b1;
        tick();

        // 1: single op, ack after 3 cycles, response captured in slot
        push_op(32'h0000_102B, 32'hDEAD_BEEF, 1);
        check("t1_req_not_yet", cpu_insn_req, 0);
        tick();
        check("t1_req_rise", cpu_insn_req, 1);
        check("t1_enc", cpu_insn_enc, 32'h0000_102B);
        tick(); tick(); tick();
        check("t1_req_cycle4", cpu_insn_req, 1);
        do_ack();
        check("t1_req_drop", cpu_insn_req, 0);
        check("t1_insn_ack", cpu_insn_ack, 1);
        do_rsp(1'b1, 5'd5, 32'h0000_1234, 3'd0, 1);
        check("t1_wb_valid", wb_valid, 1);
        check("t1_wb_waddr", wb_waddr, 5);
        check("t1_wb_wdata", wb_wdata, 32'h1234);
        tick();
        check("t1_wb_clear", wb_valid, 0);
        check("t1_busy", busy, 0);

        // 2: back-pressure with DEPTH=2, ops delivered in order
        push_op(32'hA000_0001, 32'h1111_1111, 1);
        push_op(32'hB000_0002, 32'h2222_2222, 1);
        push_op(32'hC000_0003, 32'h3333_3333, 1);
        check("t2_full", dec_ready, 0);
        begin
            req_t r;
            r.enc = 32'hD000_0004; r.rs1 = 32'h4444_4444;
            exp_req.push_back(r);
            dec_enc = r.enc; dec_rs1 = r.rs1; dec_valid = 1'b1;
        end
        tick(); tick();
        check("t2_still_full", dec_ready, 0);
        do_ack();
        do_rsp(1'b1, 5'd1, 32'h0000_00A1, 3'd0, 1);
        begin
            int i = 0;
            while (!dec_ready && i < 100) begin tick(); i++; end
            check("t2_d_accept", dec_ready, 1);
            tick();
            dec_valid = 1'b0;
        end
        wait_req(); do_ack(); do_rsp(1'b1, 5'd2, 32'h0000_00B2, 3'd3, 1);
        wait_req(); do_ack(); do_rsp(1'b0, 5'd3, 32'h0000_00C3, 3'd0, 1);
        wait_req(); do_ack(); do_rsp(1'b1, 5'd4, 32'h0000_00D4, 3'd6, 1);
        tick();
        check("t2_busy", busy, 0);

        // 3: held writeback slot blocks the response ack
        wb_ready = 1'b0;
        push_op(32'hE000_0005, 32'h5555_5555, 1);
        wait_req(); do_ack(); do_rsp(1'b1, 5'd7, 32'h0000_0E05, 3'd0, 1);
        push_op(32'hF000_0006, 32'h6666_6666, 1);
        wait_req(); do_ack();
        cop_wen = 1'b1; cop_waddr = 5'd9; cop_wdata = 32'h0000_0F06; cop_result = 3'd2;
        cop_insn_rsp = 1'b1;
        check("t3_ack_blocked", cpu_insn_ack, 0);
        tick(); tick();
        check("t3_ack_blocked2", cpu_insn_ack, 0);
        check("t3_slot_kept", wb_wdata, 32'h0E05);
        begin
            wb_t w;
            w.wen = 1'b1; w.waddr = 5'd9; w.wdata = 32'h0000_0F06; w.result = 3'd2;
            exp_wb.push_back(w);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("t3_ack_free", cpu_insn_ack, 1);
        tick();
        cop_insn_rsp = 1'b0;
        check("t3_wb_valid", wb_valid, 1);
        check("t3_wb_wdata", wb_wdata, 32'h0F06);
        wb_ready = 1'b1;
        tick();

        // 4: abort in REQ flushes the queue and discards the response
        push_op(32'h1000_0007, 32'h7777_7777, 1);
        wait_req();
        push_op(32'h2000_0008, 32'h8888_8888, 0);
        dec_abort = 1'b1;
        tick();
        dec_abort = 1'b0;
        check("t4_abort_req", cpu_abort_req, 1);
        check("t4_req_held", cpu_insn_req, 1);
        tick();
        check("t4_req_held2", cpu_insn_req, 1);
        do_ack();
        check("t4_abort_wait", cpu_abort_req, 1);
        do_rsp(1'b1, 5'd10, 32'hBAD0_0001, 3'd0, 0);
        check("t4_no_wb", wb_valid, 0);
        check("t4_abort_clr", cpu_abort_req, 0);
        tick(); tick();
        check("t4_busy", busy, 0);
        check("t4_no_reissue", cpu_insn_req, 0);

        // 5: abort with same-cycle push; committed slot survives the abort
        wb_ready = 1'b0;
        push_op(32'h3000_0009, 32'h9999_9999, 1);
        wait_req(); do_ack(); do_rsp(1'b1, 5'd11, 32'h0000_3009, 3'd0, 1);
        push_op(32'h4000_000A, 32'hAAAA_AAAA, 1);
        wait_req();
        dec_enc = 32'h5000_000B; dec_rs1 = 32'hBBBB_BBBB;
        dec_valid = 1'b1; dec_abort = 1'b1;
        tick();
        dec_valid = 1'b0; dec_abort = 1'b0;
        check("t5_wb_kept", wb_valid, 1);
        check("t5_abort_req", cpu_abort_req, 1);
        do_ack();
        do_rsp(1'b1, 5'd12, 32'hBAD0_0002, 3'd0, 0);
        check("t5_slot_data", wb_wdata, 32'h3009);
        wb_ready = 1'b1;
        tick(); tick(); tick();
        check("t5_busy", busy, 0);
        check("t5_no_issue", cpu_insn_req, 0);

        // 6: async reset while in WAIT, then normal operation
        wb_ready = 1'b0;
        push_op(32'h6000_000C, 32'hCCCC_CCCC, 1);
        wait_req(); do_ack(); do_rsp(1'b1, 5'd13, 32'h0000_600C, 3'd0, 1);
        push_op(32'h7000_000D, 32'hDDDD_DDDD, 1);
        wait_req(); do_ack();
        check("t6_pre_enc", cpu_insn_enc, 32'h7000_000D);
        #2;
        g_resetn = 1'b0;
        #1;
        void'(exp_wb.pop_front());
        check("t6_req", cpu_insn_req, 0);
        check("t6_insn_ack", cpu_insn_ack, 0);
        check("t6_abort_req", cpu_abort_req, 0);
        check("t6_wb_valid", wb_valid, 0);
        check("t6_wb_wdata", wb_wdata, 0);
        check("t6_enc", cpu_insn_enc, 0);
        check("t6_rs1", cpu_rs1, 0);
        check("t6_busy", busy, 0);
        wb_ready = 1'b1;
        tick(); tick();
        g_resetn = 1'b1;
        tick();
        push_op(32'h8000_000E, 32'hEEEE_EEEE, 1);
        wait_req(); do_ack(); do_rsp(1'b1, 5'd14, 32'h0000_800E, 3'd1, 1);
        tick(); tick();
        check("end_busy", busy, 0);
        check("end_req_queue", exp_req.size(), 0);
        check("end_wb_queue", exp_wb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
